// File: rtl/right_shift_seq_pkg.sv
// Shared shift definitions for the multicycle right shifter.
// Holds the default operand and shift-amount widths, the stage count and the
// FSM state encoding used by right_shift_seq.
// No ports (package).
package right_shift_seq_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  // One conditional stage per shift-amount bit: 16, 8, 4, 2, 1.
  localparam int STAGES = DEF_SHAMT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/right_shift_stage.sv
// One conditional right-shift stage of the multicycle shifter.
// When en is set, the input moves right by 2^k bit positions and the vacated
// MSBs take the value of fill; when en is clear the input passes through.
// Ports:
//   in    in   WIDTH  value to shift
//   fill  in   1      bit written into the vacated MSBs
//   en    in   1      1 = apply this stage, 0 = pass through
//   k     in   K_W    stage index; shift distance is 2^k
//   out   out  WIDTH  stage result
module right_shift_stage #(
  parameter int WIDTH = 32,
  parameter int K_W   = 3
) (
  input  logic [WIDTH-1:0] in,
  input  logic             fill,
  input  logic             en,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  // The fill mask marks exactly the bit positions vacated by the shift, so
  // OR-ing it in gives sign extension without needing a signed operator.
  always_comb begin
    shifted   = in >> (1 << k);
    fill_mask = ~({WIDTH{1'b1}} >> (1 << k));
    out       = in;
    if (en) begin
      out = shifted | (fill ? fill_mask : '0);
    end
  end

endmodule

// File: rtl/right_shift_seq.sv
// Multicycle 32-bit right shifter, logical (zero fill) or arithmetic (sign
// fill). One conditional stage is applied per cycle, largest first
// (16, 8, 4, 2, 1), so every operation takes a fixed five SHIFT cycles.
// Ports:
//   clock         in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high; clears all state
//   start         in   1        request; accepted only while ready=1
//   data_in       in   WIDTH    operand, sampled on the accepting edge
//   shamt         in   SHAMT_W  shift amount, sampled on the accepting edge
//   arith         in   1        1 = arithmetic, 0 = logical
//   ready         out  1        1 in IDLE or DONE
//   busy          out  1        1 in SHIFT
//   result        out  WIDTH    last completed result, held until the next one
//   result_valid  out  1        one-cycle pulse in DONE
module right_shift_seq
  import right_shift_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid
);

  localparam int K_W = $clog2(SHAMT_W);
  localparam logic [K_W-1:0] FIRST_K = K_W'(SHAMT_W - 1);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] amt;
  logic               fill;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   stage_out;

  // A single stage instance is time-shared; the counter k picks the distance.
  right_shift_stage #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_stage (
    .in   (work),
    .fill (fill),
    .en   (amt[k]),
    .k    (k),
    .out  (stage_out)
  );

  // FSM, counter and datapath registers. All outputs are registered so that
  // ready/busy/result_valid change only on clock edges. The fill bit is
  // captured once at acceptance so later stages sign-extend from the
  // original operand's MSB rather than from an intermediate value.
  // result is written only on the SHIFT->DONE edge, so it never shows a
  // partially shifted value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      work         <= '0;
      amt          <= '0;
      fill         <= 1'b0;
      k            <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= data_in;
            amt   <= shamt;
            fill  <= arith & data_in[WIDTH-1];
            k     <= FIRST_K;
            state <= SHIFT;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end

        SHIFT: begin
          work <= stage_out;
          if (k == '0) begin
            state        <= DONE;
            result       <= stage_out;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            ready        <= 1'b1;
          end else begin
            k <= k - 1'b1;
          end
        end

        DONE: begin
          // A start seen here begins the next op in the same cycle as the
          // completion pulse, giving one op per six cycles back-to-back.
          result_valid <= 1'b0;
          if (start) begin
            work  <= data_in;
            amt   <= shamt;
            fill  <= arith & data_in[WIDTH-1];
            k     <= FIRST_K;
            state <= SHIFT;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          ready        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_right_shift_seq.sv
// Self-checking bench for right_shift_seq. Expected results come from a
// behavioural shift model and are queued when an op is started, then popped
// when result_valid is seen.
module tb_right_shift_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        ready;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int n_vec;
  int n_bad;
  int pulse_count;
  bit prev_rv;
  bit double_seen;

  logic [31:0] exp_q[$];

  right_shift_seq dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .shamt        (shamt),
    .arith        (arith),
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse monitor: counts result_valid pulses and flags any two-cycle pulse.
  always @(negedge clock) begin
    if (reset) begin
      prev_rv = 1'b0;
    end else begin
      if (result_valid && prev_rv) double_seen = 1'b1;
      if (result_valid) pulse_count++;
      prev_rv = result_valid;
    end
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  // Drive start for one cycle from the current negedge; returns at the next one.
  task automatic drive_start(input logic [31:0] d, input logic [4:0] s, input logic a);
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    arith   = a;
    exp_q.push_back(model(d, s, a));
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits (bounded) for result_valid, then pops and compares the scoreboard.
  task automatic wait_result(input string name, output int lat);
    logic [31:0] exp;
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    n_vec++;
    if (!result_valid) begin
      n_bad++;
      $display("[TB] FAIL %s: timeout, result_valid=%0b required 1", name, result_valid);
    end else if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL %s: unexpected result 0x%08h, required no result", name, result);
    end else begin
      exp = exp_q.pop_front();
      if (result !== exp) begin
        n_bad++;
        $display("[TB] FAIL %s: result=0x%08h required 0x%08h", name, result, exp);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    arith   = 1'b0;
    idle(2);
    n_vec++;
    if ({ready, busy, result_valid} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: ready/busy/valid=%03b required 100",
               {ready, busy, result_valid});
    end
    n_vec++;
    if (result !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_result: result=0x%08h required 0x00000000", result);
    end
    reset = 1'b0;
    idle(2);
    n_vec++;
    if ({ready, busy, result_valid} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL post_reset_idle: ready/busy/valid=%03b required 100",
               {ready, busy, result_valid});
    end
  endtask

  task automatic test_logical();
    int lat;
    drive_start(32'h8000_0000, 5'd31, 1'b0);
    wait_result("logical_31", lat);
    n_vec++;
    if (lat !== 5) begin
      n_bad++;
      $display("[TB] FAIL logical_latency: cycles=%0d required 5", lat);
    end
    n_vec++;
    if (result !== 32'h0000_0001) begin
      n_bad++;
      $display("[TB] FAIL logical_const: result=0x%08h required 0x00000001", result);
    end
    idle(2);
    drive_start(32'h8765_4321, 5'd31, 1'b1);
    wait_result("arith_31_all_fill", lat);
    idle(2);
  endtask

  task automatic test_arith();
    int lat;
    drive_start(32'h8000_0000, 5'd4, 1'b1);
    wait_result("arith_4", lat);
    n_vec++;
    if (result !== 32'hF800_0000) begin
      n_bad++;
      $display("[TB] FAIL arith_const: result=0x%08h required 0xF8000000", result);
    end
    idle(2);
    drive_start(32'h8000_0000, 5'd4, 1'b0);
    wait_result("logical_4", lat);
    n_vec++;
    if (result !== 32'h0800_0000) begin
      n_bad++;
      $display("[TB] FAIL logical4_const: result=0x%08h required 0x08000000", result);
    end
    idle(2);
  endtask

  task automatic test_zero_shift();
    int lat;
    drive_start(32'hDEAD_BEEF, 5'd0, 1'b1);
    n_vec++;
    if ({busy, ready} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL shift_flags: busy/ready=%02b required 10", {busy, ready});
    end
    wait_result("zero_shift", lat);
    n_vec++;
    if (lat !== 5) begin
      n_bad++;
      $display("[TB] FAIL zero_latency: cycles=%0d required 5", lat);
    end
    idle(2);
  endtask

  task automatic test_busy_ignore();
    int lat;
    pulse_count = 0;
    drive_start(32'h0000_F000, 5'd12, 1'b0);
    @(negedge clock);
    // Second request lands in SHIFT and must be dropped; not queued.
    start   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd0;
    arith   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_result("busy_ignore", lat);
    n_vec++;
    if (result !== 32'h0000_000F) begin
      n_bad++;
      $display("[TB] FAIL busy_const: result=0x%08h required 0x0000000F", result);
    end
    idle(8);
    n_vec++;
    if (pulse_count !== 1) begin
      n_bad++;
      $display("[TB] FAIL busy_pulses: count=%0d required 1", pulse_count);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_start(32'h1234_5678, 5'd8, 1'b0);
    wait_result("b2b_first", lat);
    // Now in the DONE cycle: issue the next op immediately.
    drive_start(32'hFFFF_FFFE, 5'd1, 1'b1);
    wait_result("b2b_second", lat);
    n_vec++;
    if (lat + 1 !== 6) begin
      n_bad++;
      $display("[TB] FAIL b2b_gap: cycles=%0d required 6", lat + 1);
    end
    n_vec++;
    if (result !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("[TB] FAIL b2b_const: result=0x%08h required 0xFFFFFFFF", result);
    end
    idle(3);
    n_vec++;
    if (double_seen !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL valid_width: double pulse=%0b required 0", double_seen);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    drive_start(32'h1234_5678, 5'd8, 1'b0);
    idle(2);
    reset = 1'b1;
    #1;
    void'(exp_q.pop_back());
    n_vec++;
    if ({ready, busy, result_valid} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL abort_flags: ready/busy/valid=%03b required 100",
               {ready, busy, result_valid});
    end
    n_vec++;
    if (result !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL abort_result: result=0x%08h required 0x00000000", result);
    end
    @(negedge clock);
    reset = 1'b0;
    pulse_count = 0;
    idle(10);
    n_vec++;
    if (pulse_count !== 0) begin
      n_bad++;
      $display("[TB] FAIL abort_pulses: count=%0d required 0", pulse_count);
    end
    drive_start(32'h0F0F_0000, 5'd16, 1'b0);
    wait_result("after_abort", lat);
    idle(2);
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 8; i++) begin
      drive_start($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      wait_result("random", lat);
      n_vec++;
      if (lat !== 5) begin
        n_bad++;
        $display("[TB] FAIL random_latency: cycles=%0d required 5", lat);
      end
      idle(1);
    end
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_left: entries=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    pulse_count = 0;
    prev_rv     = 1'b0;
    double_seen = 1'b0;
    test_reset();
    test_logical();
    test_arith();
    test_zero_shift();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
